score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Downstream consumer of the ball/collision stage: takes its per-player point flags and keeps the match score.
- Runs the match state machine: idle, serve countdown, rally, game over.
- Drives BCD score digits for the 7-segment/score overlay, and a hold/restart handshake back to the ball stage so the ball freezes between rallies.
- Frame-timed serve delay derived from the VGA timing generator's pixel coordinates.

Parameters:
WIN_SCORE, 9, points needed to win the match; legal range 1..99.
SERVE_FRAMES, 60, number of end-of-frame ticks spent in SERVE before the rally starts; legal range 1..255.
FRAME_LAST_X, 639, o_x value of the last active pixel.
FRAME_LAST_Y, 479, o_y value of the last active line.

Ports:
clk_in  input  1  system clock (board clock), sole clock of the block
i_rst  input  1  asynchronous active-low reset (0 = reset)
o_x  input  10  current pixel x from VGA timing generator
o_y  input  9  current pixel y from VGA timing generator
pointPlayer1  input  1  point flag for player 1 from ball stage; level, only rising edges count
pointPlayer2  input  1  point flag for player 2 from ball stage; level, only rising edges count
i_start  input  1  start/restart request, active-high, asynchronous to clk_in (debounced key)
score_p1  output  8  player 1 score, BCD: [7:4] tens, [3:0] ones
score_p2  output  8  player 2 score, BCD: [7:4] tens, [3:0] ones
serve_hold  output  1  1 = ball stage must freeze the ball
ball_restart  output  1  one-cycle pulse: ball stage recentres the ball
last_scorer  output  1  0 = player 1 scored last, 1 = player 2; serve direction hint
game_over  output  1  1 while in OVER
winner  output  1  valid when game_over = 1; 0 = player 1, 1 = player 2

Behaviour:
- Reset (i_rst = 0, async assert, sync release) sets the following. State IDLE. Both scores 0x00. serve_hold = 1. ball_restart = 0. last_scorer = 0. game_over = 0. winner = 0. All edge/sync registers 0. Frame counter 0.
- i_start passes through a 2-flop synchronizer, then rising-edge detection, giving start_evt as a one-cycle pulse.
- frame_tick is a one-cycle pulse on the rising edge of (o_x == FRAME_LAST_X && o_y == FRAME_LAST_Y). The condition can hold for several clk_in cycles per pixel; it still yields exactly one tick per frame.
- p1_evt and p2_evt are rising edges of pointPlayer1 and pointPlayer2, registered against the previous-cycle value. Edge registers update in every state.
- IDLE:
  - serve_hold = 1.
  - On start_evt, go to SERVE and pulse ball_restart.
- SERVE:
  - serve_hold = 1.
  - The frame counter increments on each frame_tick.
  - When the count reaches SERVE_FRAMES, clear the counter and go to PLAY.
  - Point events are ignored.
- PLAY:
  - serve_hold = 0.
  - Exactly one of p1_evt/p2_evt: increment that player's score and set last_scorer.
    - If the new score equals WIN_SCORE, go to OVER and set winner.
    - Otherwise go to SERVE and pulse ball_restart.
  - Both events in the same cycle: neither score changes and last_scorer is unchanged. Go to SERVE with a ball_restart pulse (rally replayed).
  - start_evt in PLAY is ignored.
- OVER:
  - serve_hold = 1, game_over = 1.
  - Scores are frozen and point events are ignored.
  - On start_evt: clear both scores, clear game_over, clear the frame counter, pulse ball_restart, go to SERVE.
- Score arithmetic:
  - A 7-bit binary count per player is used for the WIN_SCORE compare.
  - BCD is kept in parallel: ones 9 -> 0 with tens +1.
  - No wrap is possible, because the count stops at WIN_SCORE ≤ 99.
- Timing:
  - Score, last_scorer, winner and state all update on the clock edge after the event cycle, giving one cycle of latency from a pointPlayer rise to the score change.
  - ball_restart is high exactly one cycle, coincident with the first cycle of the new SERVE state.
- Reset asserted mid-rally or mid-serve returns to IDLE with the reset values above. There is no partial score retention.
- A pointPlayer input held high across many frames produces only one point. A new point requires the input to fall and rise again.

Test Plan:
- Reset, then i_start pulse. Required response: ball_restart high 1 cycle; serve_hold = 1 for 60 frame ticks, then 0; scores 0x00/0x00.
- In PLAY, raise pointPlayer1 and hold it 3 frames. Required response: score_p1 = 0x01 exactly once, last_scorer = 0, back in SERVE with ball_restart pulse; further frames while still high give no extra point.
- With WIN_SCORE = 12, drive 12 separate player-2 rises (serve intervals between). Required response: score_p2 steps 0x09 -> 0x10 -> 0x11 -> 0x12; game_over = 1, winner = 1, serve_hold = 1; subsequent point rises ignored.
- pointPlayer1 and pointPlayer2 rise in the same cycle during PLAY. Required response: both scores unchanged, ball_restart pulses, state SERVE.
- Hold o_x = 639, o_y = 479 for 4 consecutive clk_in cycles during SERVE. Required response: the frame counter advances by exactly 1.
- Assert i_rst low mid-SERVE with score 0x03/0x05. Required response: scores immediately 0x00/0x00, serve_hold = 1, game_over = 0, state IDLE; no ball_restart until the next i_start.

Source files
------------

// File: rtl/score_keeper.sv
// ============================================================================
// score_keeper : match FSM, BCD score keeping and serve timing for the game
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_keeper #(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int FRAME_LAST_X = 639,
  parameter int FRAME_LAST_Y = 479
) (
  input  logic       clk_in,
  input  logic       i_rst,
  input  logic [9:0] o_x,
  input  logic [8:0] o_y,
  input  logic       pointPlayer1,
  input  logic       pointPlayer2,
  input  logic       i_start,
  output logic [7:0] score_p1,
  output logic [7:0] score_p2,
  output logic       serve_hold,
  output logic       ball_restart,
  output logic       last_scorer,
  output logic       game_over,
  output logic       winner
);

  localparam logic [9:0] LAST_X    = 10'(FRAME_LAST_X);
  localparam logic [8:0] LAST_Y    = 9'(FRAME_LAST_Y);
  localparam logic [6:0] WIN_BIN   = 7'(WIN_SCORE);
  localparam logic [7:0] SERVE_CNT = 8'(SERVE_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t     state, state_nx;

  logic       start_meta, start_sync, start_prev;
  logic       frame_prev, p1_prev, p2_prev;
  logic       start_evt, frame_cond, frame_tick, p1_evt, p2_evt;

  logic [7:0] frame_cnt, frame_cnt_nx;
  logic [6:0] bin_p1, bin_p2;
  logic       restart_nx, inc_p1, inc_p2, clr_scores;
  logic       last_nx, winner_nx;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign frame_cond = (o_x == LAST_X) && (o_y == LAST_Y);
  assign frame_tick = frame_cond & ~frame_prev;
  assign start_evt  = start_sync & ~start_prev;
  assign p1_evt     = pointPlayer1 & ~p1_prev;
  assign p2_evt     = pointPlayer2 & ~p2_prev;

  // Synchronizer and edge-history registers run in every state.
  always_ff @(posedge clk_in or negedge i_rst) begin
    if (!i_rst) begin
      start_meta <= 1'b0;
      start_sync <= 1'b0;
      start_prev <= 1'b0;
      frame_prev <= 1'b0;
      p1_prev    <= 1'b0;
      p2_prev    <= 1'b0;
    end else begin
      start_meta <= i_start;
      start_sync <= start_meta;
      start_prev <= start_sync;
      frame_prev <= frame_cond;
      p1_prev    <= pointPlayer1;
      p2_prev    <= pointPlayer2;
    end
  end

  always_ff @(posedge clk_in or negedge i_rst) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    frame_cnt_nx = frame_cnt;
    restart_nx   = 1'b0;
    inc_p1       = 1'b0;
    inc_p2       = 1'b0;
    clr_scores   = 1'b0;
    last_nx      = last_scorer;
    winner_nx    = winner;
    serve_hold   = 1'b1;
    game_over    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_evt) begin
          state_nx   = ST_SERVE;
          restart_nx = 1'b1;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (frame_cnt + 8'd1 == SERVE_CNT) begin
            frame_cnt_nx = 8'd0;
            state_nx     = ST_PLAY;
          end else begin
            frame_cnt_nx = frame_cnt + 8'd1;
          end
        end
      end
      ST_PLAY: begin
        serve_hold = 1'b0;
        if (p1_evt && p2_evt) begin
          // Simultaneous points: replay the rally without scoring.
          state_nx   = ST_SERVE;
          restart_nx = 1'b1;
        end else if (p1_evt) begin
          inc_p1  = 1'b1;
          last_nx = 1'b0;
          if (bin_p1 + 7'd1 == WIN_BIN) begin
            state_nx  = ST_OVER;
            winner_nx = 1'b0;
          end else begin
            state_nx   = ST_SERVE;
            restart_nx = 1'b1;
          end
        end else if (p2_evt) begin
          inc_p2  = 1'b1;
          last_nx = 1'b1;
          if (bin_p2 + 7'd1 == WIN_BIN) begin
            state_nx  = ST_OVER;
            winner_nx = 1'b1;
          end else begin
            state_nx   = ST_SERVE;
            restart_nx = 1'b1;
          end
        end
      end
      ST_OVER: begin
        game_over = 1'b1;
        if (start_evt) begin
          clr_scores   = 1'b1;
          frame_cnt_nx = 8'd0;
          restart_nx   = 1'b1;
          state_nx     = ST_SERVE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge i_rst) begin
    if (!i_rst) begin
      frame_cnt    <= 8'd0;
      bin_p1       <= 7'd0;
      bin_p2       <= 7'd0;
      score_p1     <= 8'h00;
      score_p2     <= 8'h00;
      ball_restart <= 1'b0;
      last_scorer  <= 1'b0;
      winner       <= 1'b0;
    end else begin
      frame_cnt    <= frame_cnt_nx;
      ball_restart <= restart_nx;
      last_scorer  <= last_nx;
      winner       <= winner_nx;
      if (clr_scores) begin
        bin_p1   <= 7'd0;
        bin_p2   <= 7'd0;
        score_p1 <= 8'h00;
        score_p2 <= 8'h00;
      end else begin
        if (inc_p1) begin
          bin_p1   <= bin_p1 + 7'd1;
          score_p1 <= bcd_inc(score_p1);
        end
        if (inc_p2) begin
          bin_p2   <= bin_p2 + 7'd1;
          score_p2 <= bcd_inc(score_p2);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// ============================================================================
// tb_score_keeper : scoreboard bench for score_keeper (WIN_SCORE = 12)
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_keeper;

  localparam int WIN = 12;
  localparam int SF  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] px = 10'd0;
  logic [8:0] py = 9'd0;
  logic       pp1 = 1'b0, pp2 = 1'b0, start = 1'b0;
  logic [7:0] score_p1, score_p2;
  logic       serve_hold, ball_restart, last_scorer, game_over, winner;

  score_keeper #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF),
                 .FRAME_LAST_X(639), .FRAME_LAST_Y(479)) dut (
    .clk_in(clk), .i_rst(rst_n), .o_x(px), .o_y(py),
    .pointPlayer1(pp1), .pointPlayer2(pp2), .i_start(start),
    .score_p1(score_p1), .score_p2(score_p2), .serve_hold(serve_hold),
    .ball_restart(ball_restart), .last_scorer(last_scorer),
    .game_over(game_over), .winner(winner));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] p1;
    logic [7:0] p2;
    logic       last;
    logic       over;
    logic       win;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_evt   = 0;
  logic over_prev = 1'b0;
  int   exp1 = 0, exp2 = 0;
  logic exp_last = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  // Output events: a ball_restart pulse or entry into game over.
  always @(negedge clk) begin
    if (!rst_n) begin
      over_prev = 1'b0;
    end else begin
      if (ball_restart || (game_over && !over_prev)) begin
        if (q.size() == 0) begin
          check("sb_unexpected_event", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sb_score_p1", score_p1, e.p1);
          check("sb_score_p2", score_p2, e.p2);
          check("sb_last", last_scorer, e.last);
          check("sb_game_over", game_over, e.over);
          check("sb_restart", ball_restart, !e.over);
          if (e.over) check("sb_winner", winner, e.win);
        end
        n_evt++;
      end
      over_prev = game_over;
    end
  end

  task automatic push(input logic over, input logic win);
    exp_t e;
    e.p1 = to_bcd(exp1); e.p2 = to_bcd(exp2);
    e.last = exp_last; e.over = over; e.win = win;
    q.push_back(e);
  endtask

  task automatic wait_evt(input int target, input string tag);
    for (int i = 0; i < 200 && n_evt < target; i++) @(negedge clk);
    check(tag, n_evt >= target, 1);
  endtask

  task automatic frame(input int hold);
    @(posedge clk); #1;
    px = 10'd639; py = 9'd479;
    repeat (hold) @(posedge clk);
    #1; px = 10'd0; py = 9'd0;
    repeat (2) @(posedge clk);
  endtask

  task automatic serve_frames();
    repeat (SF) frame(2);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic point(input bit who);
    @(posedge clk); #1;
    if (who) pp2 = 1'b1; else pp1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 pp1 = 1'b0; pp2 = 1'b0;
  endtask

  initial begin
    int tgt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_p1", score_p1, 8'h00);
    check("rst_p2", score_p2, 8'h00);
    check("rst_hold", serve_hold, 1);
    check("rst_restart", ball_restart, 0);
    check("rst_last", last_scorer, 0);
    check("rst_over", game_over, 0);
    check("rst_winner", winner, 0);
    #2 rst_n = 1'b1;

    // Start the match; serve lasts exactly SF ticks, each held 4 cycles.
    push(1'b0, 1'b0); tgt = 1;
    pulse_start();
    wait_evt(tgt, "to_start");
    repeat (SF - 1) frame(4);
    @(negedge clk);
    check("serve_hold_before_last_tick", serve_hold, 1);
    frame(4);
    @(negedge clk);
    check("serve_hold_play", serve_hold, 0);

    // Held point flag scores exactly once.
    exp1 = 1; exp_last = 1'b0; push(1'b0, 1'b0); tgt++;
    @(posedge clk); #1 pp1 = 1'b1;
    wait_evt(tgt, "to_p1_held");
    serve_frames();
    check("held_play", serve_hold, 0);
    repeat (3) frame(2);
    @(negedge clk);
    check("held_no_extra", score_p1, 8'h01);
    check("held_still_play", serve_hold, 0);
    @(posedge clk); #1 pp1 = 1'b0;

    // Simultaneous points replay the rally.
    push(1'b0, 1'b0); tgt++;
    @(posedge clk); #1 pp1 = 1'b1; pp2 = 1'b1;
    wait_evt(tgt, "to_both");
    check("both_hold", serve_hold, 1);
    #1 pp1 = 1'b0; pp2 = 1'b0;
    serve_frames();

    // Player 2 runs to WIN, crossing the BCD tens boundary.
    for (int k = 1; k <= WIN; k++) begin
      exp2 = k; exp_last = 1'b1;
      push(k == WIN, 1'b1); tgt++;
      point(1'b1);
      wait_evt(tgt, "to_p2_run");
      if (k < WIN) serve_frames();
    end
    @(negedge clk);
    check("over_flag", game_over, 1);
    check("over_winner", winner, 1);
    check("over_hold", serve_hold, 1);
    point(1'b0);
    point(1'b1);
    repeat (3) @(negedge clk);
    check("over_frozen_p1", score_p1, 8'h01);
    check("over_frozen_p2", score_p2, to_bcd(WIN));

    // Restart from OVER, build 3/5, then reset mid-serve.
    exp1 = 0; exp2 = 0; push(1'b0, 1'b0); tgt++;
    pulse_start();
    wait_evt(tgt, "to_restart");
    check("restart_over_clr", game_over, 0);
    serve_frames();
    for (int k = 0; k < 8; k++) begin
      bit who;
      who = (k >= 3);
      if (who) exp2++; else exp1++;
      exp_last = who;
      push(1'b0, 1'b0); tgt++;
      point(who);
      wait_evt(tgt, "to_build");
      if (k < 7) serve_frames();
    end
    frame(2);
    @(negedge clk);
    check("pre_rst_p1", score_p1, 8'h03);
    check("pre_rst_p2", score_p2, 8'h05);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("mid_rst_p1", score_p1, 8'h00);
    check("mid_rst_p2", score_p2, 8'h00);
    check("mid_rst_hold", serve_hold, 1);
    check("mid_rst_over", game_over, 0);
    check("mid_rst_last", last_scorer, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (SF + 1) frame(2);
    @(negedge clk);
    check("idle_no_restart", n_evt, tgt);
    check("idle_hold", serve_hold, 1);

    exp1 = 0; exp2 = 0; exp_last = 1'b0; push(1'b0, 1'b0); tgt++;
    pulse_start();
    wait_evt(tgt, "to_start_after_rst");
    check("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
